mem_bist_master: RTL and testbench
==================================

Name: mem_bist_master

Overview:
- Hardware initiator for the mem_intf request/grant protocol; drives the slave port of mem_ctrl (or a mem_group directly).
- On a start pulse it runs two phases over a word range:
  - sequential writes of a counting pattern;
  - sequential reads, each response compared against the expected pattern.
- Reports pass/fail, error count and first failing address.
- Replaces testbench-driven write/read tasks with synthesizable traffic for bring-up and on-chip self-test.

Parameters:
- DATA_WIDTH, 32, width of write/read data; DATA_BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32, byte address width.
- CNT_WIDTH, 16, width of word count and error counter.
- MAX_OUTSTANDING, 4, maximum granted reads awaiting response (power of 2, >=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle start pulse, sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first byte address (low log2(DATA_BYTES) bits ignored, treated as 0).
- word_cnt_i  in  CNT_WIDTH  number of words to test.
- seed_i  in  DATA_WIDTH  pattern seed.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse at end of test.
- pass_o  out  1  valid from done_o until next start; 1 = zero mismatches.
- err_cnt_o  out  CNT_WIDTH  mismatch count, saturating.
- first_err_addr_o  out  ADDR_WIDTH  address of first mismatch; 0 if none.
- req_o  out  1  mem_intf req.
- gnt_i  in  1  mem_intf gnt.
- addr_o  out  ADDR_WIDTH  mem_intf addr.
- wdata_o  out  DATA_WIDTH  mem_intf data.
- be_o  out  DATA_BYTES  mem_intf be; always all ones.
- wen_o  out  1  mem_intf wen; 1 = write.
- r_valid_i  in  1  mem_intf r_valid.
- r_data_i  in  DATA_WIDTH  mem_intf r_data.
- r_ready_o  out  1  mem_intf r_ready.

Behaviour:
- Clock/reset: clock is clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0 except be_o = all ones; FSM = IDLE; all counters = 0.
- Pattern: word i has address base + i*DATA_BYTES and data seed + i, modulo 2^ADDR_WIDTH and 2^DATA_WIDTH.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - start_i = 1 latches the inputs, clears err_cnt_o, pass_o and first_err_addr_o, and sets busy_o next cycle.
  - Go to WRITE, or to DONE if word_cnt_i = 0.
- Request handshake:
  - req_o, addr_o, wdata_o and wen_o are registered outputs.
  - They are held stable while req_o = 1 and gnt_i = 0.
  - A transfer completes on a posedge with req_o && gnt_i.
  - The next request is presented in the following cycle: back-to-back, one request per cycle when gnt_i is held high.
- WRITE:
  - wen_o = 1; issue words 0..N-1.
  - After the grant of word N-1, go to READ (no bubble required).
- READ:
  - wen_o = 0, r_ready_o = 1; issue words 0..N-1.
  - req_o is deasserted while outstanding = MAX_OUTSTANDING, unless a response retires in the same cycle.
  - Outstanding counter: +1 on read grant, -1 on r_valid_i && r_ready_o; simultaneous grant and retire leaves it unchanged.
  - After the grant of the last read, go to DRAIN.
- Response checking:
  - Responses return in order.
  - Each is compared to seed + k, where k is the response index.
  - On mismatch, err_cnt_o increments (saturating at all ones).
  - The first mismatch captures base + k*DATA_BYTES into first_err_addr_o.
- DRAIN: r_ready_o = 1; when outstanding reaches 0, go to DONE.
- DONE:
  - One cycle: done_o = 1, pass_o = (err_cnt == 0), busy_o = 0; then IDLE.
  - r_ready_o = 0 outside READ/DRAIN.
- start_i while not in IDLE is ignored.
- Error conditions:
  - r_valid_i with outstanding = 0 is ignored and does not underflow the counter.
  - Assertion: error counted only when MEM_BIST_TIMEOUT_EN is defined.
- Reset mid-test aborts immediately: req_o drops asynchronously, all state returns to reset values, and pending responses are discarded.

Optional Feature:
- Macro: MEM_BIST_TIMEOUT_EN.
- Defined:
  - Adds a 16-bit wait counter that counts cycles with (req_o && !gnt_i), or with outstanding > 0 and no r_valid_i.
  - The counter clears on any grant or response.
  - When it reaches 16'hFFFF: abort to DONE, drop req_o, set pass_o = 0, and assert timeout_o (extra output port, 1 bit) together with done_o.
  - Stray responses (r_valid_i with outstanding = 0) increment err_cnt_o.
- Not defined: no timeout_o port and no counter; stalls wait indefinitely; stray responses are ignored.

Test Plan:
- Basic pass:
  - Stimulus: base = 0, word_cnt = 128, seed = 0; mem_ctrl with 4 mem_groups; gnt_i always high.
  - Response: 128 writes then 128 reads; done_o once; pass_o = 1; err_cnt_o = 0; words 0..127 hold 0..127.
- Backpressure:
  - Stimulus: responder deasserts gnt_i randomly at 50%; base = 0x100, word_cnt = 16, seed = 0xA5A5_0000.
  - Response: request fields stable during every stall; exactly 32 grants; pass_o = 1.
- Outstanding limit:
  - Stimulus: responder delays r_valid_i by 8 cycles; MAX_OUTSTANDING = 4; word_cnt = 10.
  - Response: outstanding never exceeds 4; req_o low while at limit; pass_o = 1.
- Fault injection:
  - Stimulus: responder corrupts bit 0 of read data for word 5 and word 9; base = 0x40.
  - Response: err_cnt_o = 2; first_err_addr_o = 0x54; pass_o = 0.
- Boundaries:
  - Stimulus: word_cnt = 0; also start_i pulsed during a running test.
  - Response: word_cnt = 0 gives done_o 2 cycles after start, pass_o = 1, no req_o; a second start while busy is ignored.
- Reset mid-test:
  - Stimulus: assert rst_ni low during READ with 3 reads outstanding.
  - Response: req_o and busy_o drop without waiting for a clock edge; a new start after release runs cleanly.
  - With MEM_BIST_TIMEOUT_EN: gnt_i held low gives timeout_o = 1 and pass_o = 0 after 65535 cycles.

Source files
------------

// File: rtl/mem_bist_master.sv
// Memory BIST initiator on the mem_intf req/gnt protocol: writes a counting pattern, reads it back, checks it.
// Optional MEM_BIST_TIMEOUT_EN adds a stall watchdog (timeout_o) and counts stray responses as errors.
module mem_bist_master #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [CNT_WIDTH-1:0]    word_cnt_i,
  input  logic [DATA_WIDTH-1:0]   seed_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o,
  output logic [ADDR_WIDTH-1:0]   first_err_addr_o,
  output logic                    req_o,
  input  logic                    gnt_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic                    wen_o,
  input  logic                    r_valid_i,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  output logic                    r_ready_o
`ifdef MEM_BIST_TIMEOUT_EN
  ,output logic                   timeout_o
`endif
);

  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(DATA_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);
  localparam logic [OUT_W-1:0]      OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d, wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, base_q, base_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, exp_data_q, exp_data_d;
  logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d, cnt_q, cnt_d, idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  first_err_q, first_err_d, exp_addr_q, exp_addr_d;
  logic                   err_seen_q, err_seen_d;
  logic [OUT_W-1:0]       out_q, out_d;
  logic                   grant, rd_grant, retire, err_inc;
  logic [ADDR_WIDTH-1:0]  base_al;
  logic [CNT_WIDTH-1:0]   last_idx;
`ifdef MEM_BIST_TIMEOUT_EN
  logic [15:0]            wait_q, wait_d;
  logic                   to_flag_q, to_flag_d, timeout_q, timeout_d;
`endif

  assign grant     = req_q && gnt_i;
  assign rd_grant  = grant && (state_q == READ);
  assign r_ready_o = (state_q == READ) || (state_q == DRAIN);
  // Responses with nothing outstanding never retire, so the counter cannot underflow.
  assign retire    = r_valid_i && r_ready_o && (out_q != '0);
  assign base_al   = base_addr_i & ALIGN_MASK;
  assign last_idx  = cnt_q - CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_seen_d  = err_seen_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    exp_data_d  = exp_data_q;
    exp_addr_d  = exp_addr_q;
    out_d       = out_q + OUT_W'(rd_grant) - OUT_W'(retire);
    err_inc     = 1'b0;
`ifdef MEM_BIST_TIMEOUT_EN
    wait_d      = wait_q;
    to_flag_d   = to_flag_q;
    timeout_d   = 1'b0;
    if (r_valid_i && r_ready_o && (out_q == '0)) err_inc = 1'b1;
    if (state_q == IDLE || state_q == DONE || grant || r_valid_i) wait_d = '0;
    else if ((req_q && !gnt_i) || (out_q != '0)) wait_d = wait_q + 16'd1;
`endif

    if (retire) begin
      exp_data_d = exp_data_q + DATA_WIDTH'(1);
      exp_addr_d = exp_addr_q + ADDR_STEP;
      if (r_data_i != exp_data_q) begin
        err_inc = 1'b1;
        if (!err_seen_q) begin
          first_err_d = exp_addr_q;
          err_seen_d  = 1'b1;
        end
      end
    end
    if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d      = base_al;
          cnt_d       = word_cnt_i;
          idx_d       = '0;
          out_d       = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          err_seen_d  = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          addr_d      = base_al;
          wdata_d     = seed_i;
          wen_d       = 1'b1;
          exp_data_d  = seed_i;
          exp_addr_d  = base_al;
`ifdef MEM_BIST_TIMEOUT_EN
          to_flag_d   = 1'b0;
`endif
          if (word_cnt_i == '0) state_d = DONE;
          else begin
            state_d = WRITE;
            req_d   = 1'b1;
          end
        end
      end
      WRITE: begin
        if (grant) begin
          if (idx_q == last_idx) begin
            // Read phase restarts at word 0 with no bubble.
            state_d = READ;
            idx_d   = '0;
            addr_d  = base_q;
            wen_d   = 1'b0;
          end else begin
            idx_d   = idx_q + CNT_WIDTH'(1);
            addr_d  = addr_q + ADDR_STEP;
            wdata_d = wdata_q + DATA_WIDTH'(1);
          end
        end
      end
      READ: begin
        if (grant) begin
          if (idx_q == last_idx) begin
            state_d = DRAIN;
            req_d   = 1'b0;
          end else begin
            idx_d  = idx_q + CNT_WIDTH'(1);
            addr_d = addr_q + ADDR_STEP;
            req_d  = (out_d < OUT_MAX);
          end
        end else if (!req_q) begin
          req_d = (out_d < OUT_MAX);
        end
      end
      DRAIN: begin
        if (out_d == '0) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef MEM_BIST_TIMEOUT_EN
        pass_d    = (err_cnt_q == '0) && !to_flag_q;
        timeout_d = to_flag_q;
`else
        pass_d    = (err_cnt_q == '0);
`endif
      end
      default: state_d = IDLE;
    endcase

`ifdef MEM_BIST_TIMEOUT_EN
    // Watchdog abort: abandon any in-flight reads and report through DONE.
    if ((wait_q == 16'hFFFF) && (state_q == WRITE || state_q == READ || state_q == DRAIN)) begin
      state_d   = DONE;
      req_d     = 1'b0;
      out_d     = '0;
      to_flag_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      err_seen_q  <= 1'b0;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      exp_data_q  <= '0;
      exp_addr_q  <= '0;
      out_q       <= '0;
`ifdef MEM_BIST_TIMEOUT_EN
      wait_q      <= '0;
      to_flag_q   <= 1'b0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      err_seen_q  <= err_seen_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      exp_data_q  <= exp_data_d;
      exp_addr_q  <= exp_addr_d;
      out_q       <= out_d;
`ifdef MEM_BIST_TIMEOUT_EN
      wait_q      <= wait_d;
      to_flag_q   <= to_flag_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign req_o            = req_q;
  assign addr_o           = addr_q;
  assign wdata_o          = wdata_q;
  assign wen_o            = wen_q;
  assign be_o             = '1;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
`ifdef MEM_BIST_TIMEOUT_EN
  assign timeout_o        = timeout_q;
`endif

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: memory responder with random grants, response latency and data corruption,
// table of test cases plus random cases scored against a word-level model.
module tb_mem_bist_master;
  localparam int MAXO = 4;

  logic        clk, rst_n, start_i;
  logic [31:0] base_addr_i, seed_i;
  logic [15:0] word_cnt_i;
  logic        busy_o, done_o, pass_o;
  logic [15:0] err_cnt_o;
  logic [31:0] first_err_addr_o;
  logic        req_o, gnt_i, wen_o, r_valid_i, r_ready_o;
  logic [31:0] addr_o, wdata_o, r_data_i;
  logic [3:0]  be_o;
`ifdef MEM_BIST_TIMEOUT_EN
  logic        timeout_o;
`endif

  mem_bist_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .word_cnt_i(word_cnt_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .wen_o(wen_o), .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_ready_o(r_ready_o)
`ifdef MEM_BIST_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] base;
    int          cnt;
    logic [31:0] seed;
    int          gnt_pct;
    int          lat;
    int          ca;
    int          cb;
    bit          stray;
    int          restart_at;
    int          exp_err;
    logic [31:0] exp_first;
    bit          exp_pass;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  int checks = 0;
  int errors = 0;

  // Responder state
  int          cyc = 0;
  int          gnt_pct = 100, lat = 1, ca = -1, cb = -1;
  bit          stray_en = 1'b0;
  logic [31:0] cur_base, cur_seed;
  rsp_t        pend[$];
  logic [31:0] mem [logic [31:0]];
  int          wr_cnt, rd_cnt, grants, done_cnt, req_cycles, max_out;
  int          order_viol, stab_viol, out_viol, rdy_viol;
  logic        stall_prev;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_wen;
  logic        got_pass, got_busy, got_to;
  logic [15:0] got_err;
  logic [31:0] got_first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Memory responder: decides grant/response mid-cycle and watches protocol rules.
  initial begin
    gnt_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; stall_prev = 1'b0;
    prev_addr = '0; prev_wdata = '0; prev_wen = 1'b0;
    forever begin : resp_loop
      int          outq;
      int          k;
      logic [31:0] d;
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        gnt_i = 1'b0; r_valid_i = 1'b0; stall_prev = 1'b0;
        continue;
      end
      outq = pend.size();
      if (outq > max_out) max_out = outq;
      if (outq > MAXO || (outq == MAXO && req_o)) out_viol++;
      if (stall_prev && (!req_o || addr_o != prev_addr || wdata_o != prev_wdata || wen_o != prev_wen))
        stab_viol++;
      if (req_o) req_cycles++;
      if (done_o) begin
        done_cnt++;
        got_pass = pass_o; got_err = err_cnt_o; got_first = first_err_addr_o; got_busy = busy_o;
`ifdef MEM_BIST_TIMEOUT_EN
        got_to = timeout_o;
`else
        got_to = 1'b0;
`endif
      end
      gnt_i = (int'($urandom_range(99)) < gnt_pct);
      if (req_o && gnt_i) begin
        grants++;
        if (wen_o) begin
          if (addr_o != cur_base + 32'(wr_cnt) * 4 || wdata_o != cur_seed + 32'(wr_cnt)) order_viol++;
          mem[addr_o] = wdata_o;
          wr_cnt++;
        end else begin
          if (addr_o != cur_base + 32'(rd_cnt) * 4) order_viol++;
          k = int'((addr_o - cur_base) >> 2);
          d = mem.exists(addr_o) ? mem[addr_o] : 32'h0;
          if (k == ca || k == cb) d[0] = ~d[0];
          pend.push_back('{data: d, due: cyc + lat});
          rd_cnt++;
        end
      end
      stall_prev = req_o && !gnt_i;
      prev_addr = addr_o; prev_wdata = wdata_o; prev_wen = wen_o;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        if (!r_ready_o) rdy_viol++;
        r_valid_i = 1'b1;
        r_data_i  = pend[0].data;
        void'(pend.pop_front());
      end else if (stray_en && outq == 0 && r_ready_o) begin
        r_valid_i = 1'b1;
        r_data_i  = $urandom;
      end else begin
        r_valid_i = 1'b0;
        r_data_i  = $urandom;
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] base, input int cnt, input logic [31:0] seed,
                              input int gp, input int lt, input int a, input int b, input bit st,
                              input int rs, input int ee, input logic [31:0] ef, input bit ep);
    vec_t v;
    v.base = base; v.cnt = cnt; v.seed = seed; v.gnt_pct = gp; v.lat = lt; v.ca = a; v.cb = b;
    v.stray = st; v.restart_at = rs; v.exp_err = ee; v.exp_first = ef; v.exp_pass = ep;
    return v;
  endfunction

  // Expected outcome from the word-level rules: every corrupted word in range is one mismatch.
  function automatic vec_t model(input vec_t v);
    int n = 0;
    int kmin = -1;
    if (v.ca >= 0 && v.ca < v.cnt) begin n++; kmin = v.ca; end
    if (v.cb >= 0 && v.cb < v.cnt && v.cb != v.ca) begin
      n++;
      if (kmin < 0 || v.cb < kmin) kmin = v.cb;
    end
    v.exp_err   = n;
    v.exp_first = (kmin < 0) ? 32'h0 : (v.base & 32'hFFFF_FFFC) + 32'(kmin) * 4;
    v.exp_pass  = (n == 0);
    return v;
  endfunction

  task automatic prep(input vec_t v);
    mem.delete();
    wr_cnt = 0; rd_cnt = 0; grants = 0; done_cnt = 0; req_cycles = 0; max_out = 0;
    order_viol = 0; stab_viol = 0; out_viol = 0; rdy_viol = 0;
    cur_base = v.base & 32'hFFFF_FFFC; cur_seed = v.seed;
    gnt_pct = v.gnt_pct; lat = v.lat; ca = v.ca; cb = v.cb; stray_en = v.stray;
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    base_addr_i = v.base; word_cnt_i = 16'(v.cnt); seed_i = v.seed; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    for (int i = 0; i < bound && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) begin
      errors++; checks++;
      $display("FAIL %s:done_timeout actual=0 required=1", nm);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string nm, input vec_t v);
    int bad;
    prep(v);
    launch(v);
    if (v.restart_at > 0) begin
      repeat (v.restart_at) @(negedge clk);
      base_addr_i = 32'h0BAD_0000; word_cnt_i = 16'd3; seed_i = 32'hDEAD; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_done(nm, 500 + v.cnt * 40);
    chk({nm, ":done_once"}, 32'(done_cnt), 32'd1);
    chk({nm, ":pass"}, 32'(got_pass), 32'(v.exp_pass));
    chk({nm, ":err_cnt"}, 32'(got_err), 32'(v.exp_err));
    chk({nm, ":first_err"}, got_first, v.exp_first);
    chk({nm, ":busy_at_done"}, 32'(got_busy), 32'd0);
    chk({nm, ":timeout"}, 32'(got_to), 32'd0);
    chk({nm, ":pass_held"}, 32'(pass_o), 32'(v.exp_pass));
    chk({nm, ":grants"}, 32'(grants), 32'(2 * v.cnt));
    chk({nm, ":order"}, 32'(order_viol), 32'd0);
    chk({nm, ":stable"}, 32'(stab_viol), 32'd0);
    chk({nm, ":outstanding"}, 32'(out_viol), 32'd0);
    chk({nm, ":r_ready"}, 32'(rdy_viol), 32'd0);
    bad = 0;
    for (int i = 0; i < v.cnt; i++) begin
      logic [31:0] a;
      a = cur_base + 32'(i) * 4;
      if (!mem.exists(a) || mem[a] != v.seed + 32'(i)) bad++;
    end
    chk({nm, ":mem_contents"}, 32'(bad), 32'd0);
    if (v.lat >= 8 && v.gnt_pct == 100 && v.cnt >= MAXO)
      chk({nm, ":reached_limit"}, 32'(max_out), 32'(MAXO));
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    bit   found;
    bit   st;
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; word_cnt_i = '0; seed_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst:req", 32'(req_o), 0);
    chk("rst:busy", 32'(busy_o), 0);
    chk("rst:done", 32'(done_o), 0);
    chk("rst:pass", 32'(pass_o), 0);
    chk("rst:err_cnt", 32'(err_cnt_o), 0);
    chk("rst:first_err", first_err_addr_o, 0);
    chk("rst:be", 32'(be_o), 32'hF);
    chk("rst:wen", 32'(wen_o), 0);
    chk("rst:addr", addr_o, 0);
    chk("rst:wdata", wdata_o, 0);
    chk("rst:r_ready", 32'(r_ready_o), 0);
    rst_n = 1'b1;

`ifdef MEM_BIST_TIMEOUT_EN
    st = 1'b0;
`else
    st = 1'b1;
`endif
    //              base          cnt  seed          gnt lat ca  cb  stray rst err first         pass
    vecs.push_back(mk(32'h0,        128, 32'h0,        100, 1, -1, -1, 0,  0,  0, 32'h0,        1));
    vecs.push_back(mk(32'h100,      16,  32'hA5A5_0000, 50, 1, -1, -1, 0,  0,  0, 32'h0,        1));
    vecs.push_back(mk(32'h0,        10,  32'h1234,     100, 8, -1, -1, 0,  0,  0, 32'h0,        1));
    vecs.push_back(mk(32'h40,       16,  32'h0,        100, 1,  5,  9, 0,  0,  2, 32'h54,       0));
    vecs.push_back(mk(32'h43,       4,   32'hFFFF_FFFE, 80, 3,  3, -1, 0,  0,  1, 32'h4C,       0));
    vecs.push_back(mk(32'hFFFF_FFFC, 1,  32'h5,        100, 2,  0, -1, 0,  0,  1, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(32'h200,      8,   32'h77,       100, 2, -1, -1, 0,  4,  0, 32'h0,        1));
    vecs.push_back(mk(32'h1000,     12,  32'h9,         70, 5, -1, -1, st, 0,  0, 32'h0,        1));
    for (int r = 0; r < 6; r++) begin
      int c;
      c = int'($urandom_range(1, 40));
      v = mk($urandom, c, $urandom, int'($urandom_range(30, 100)), int'($urandom_range(1, 10)),
             ($urandom_range(2) == 0) ? -1 : int'($urandom_range(0, c - 1)),
             ($urandom_range(2) == 0) ? -1 : int'($urandom_range(0, c - 1)),
             st & 1'($urandom_range(1)), 0, 0, 32'h0, 0);
      vecs.push_back(model(v));
    end
    foreach (vecs[i]) run_case($sformatf("case%0d", i), vecs[i]);

    // Zero-length test: done two cycles after start, no traffic.
    v = mk(32'h80, 0, 32'h1, 100, 1, -1, -1, 0, 0, 0, 32'h0, 1);
    prep(v);
    @(negedge clk);
    base_addr_i = 32'h80; word_cnt_i = 16'd0; start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    chk("zero:busy_c1", 32'(busy_o), 1);
    chk("zero:done_c1", 32'(done_o), 0);
    @(negedge clk); #1;
    chk("zero:done_c2", 32'(done_o), 1);
    chk("zero:busy_c2", 32'(busy_o), 0);
    chk("zero:pass", 32'(pass_o), 1);
    @(negedge clk); #1;
    chk("zero:done_c3", 32'(done_o), 0);
    chk("zero:no_req", 32'(req_cycles), 0);

    // Reset while three reads are outstanding.
    v = mk(32'h300, 32, 32'h55, 100, 8, -1, -1, 0, 0, 0, 32'h0, 1);
    prep(v);
    launch(v);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #2;
      if (rd_cnt > 0 && pend.size() == 3 && !wen_o) found = 1'b1;
    end
    chk("rst_mid:three_outstanding", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid:req", 32'(req_o), 0);
    chk("rst_mid:busy", 32'(busy_o), 0);
    chk("rst_mid:r_ready", 32'(r_ready_o), 0);
    chk("rst_mid:err_cnt", 32'(err_cnt_o), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_case("after_rst", mk(32'h300, 20, 32'h55, 90, 4, -1, -1, 0, 0, 0, 32'h0, 1));

`ifdef MEM_BIST_TIMEOUT_EN
    v = mk(32'h500, 4, 32'h1, 0, 1, -1, -1, 0, 0, 0, 32'h0, 0);
    prep(v);
    launch(v);
    wait_done("timeout", 70000);
    chk("timeout:done_once", 32'(done_cnt), 1);
    chk("timeout:flag", 32'(got_to), 1);
    chk("timeout:pass", 32'(got_pass), 0);
    chk("timeout:grants", 32'(grants), 0);
    chk("timeout:req_dropped", 32'(req_o), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
